mux_pipe_stage: RTL
===================

// Module: mux_pipe_stage
// PURPOSE
//  Parametrised N-way, WIDTH-bit selector with a registered, handshaked output.
//  Replaces the plain combinational 2:1 datapath mux wherever a select sits on a
//  pipeline boundary, e.g. a forwarding / writeback select feeding the next stage.
//  A 2-entry skid buffer gives full throughput under backpressure.
//  Out-of-range selects are flagged and produce zero data.
// PARAMETERS
//  WIDTH   32  data width of each input channel and of the output
//  N       2   number of input channels, 2..16
//  SELW    $clog2(N) (localparam, min 1) select width
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_data    in   N*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//  in_sel     in   SELW     channel select, sampled with in_valid
//  in_valid   in   1        upstream word valid
//  in_ready   out  1        stage can accept this cycle
//  out_data   out  WIDTH    selected word
//  out_valid  out  1        out_data valid
//  out_ready  in   1        downstream accepts this cycle
//  flush      in   1        synchronous pipeline flush (branch/exception)
//  sel_err    out  1        sticky: an out-of-range select was accepted
//  err_clr    in   1        synchronous clear of sel_err
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_data=0, skid empty, in_ready=1
//    after release, sel_err=0. Reset mid-transfer drops all held words.
//  - Accept: in_valid & in_ready at edge. Selected word = in_data[in_sel] if
//    in_sel<N, else all-zero with sel_err set at the same edge.
//  - Latency 1: word accepted at edge t is on out_data/out_valid after edge t.
//  - Storage: main reg (drives out_*) + skid reg. in_ready = ~skid_valid
//    (registered, no combinational path from out_ready).
//  - Per edge, by main/skid occupancy (E=empty, M=main only, F=both):
//    E: accept -> M.
//    M: out_ready & accept -> M (new word); out_ready only -> E;
//       accept only -> F (new word to skid); neither -> M hold.
//    F: out_ready -> M (skid moves to main); no accept possible (in_ready=0).
//  - out_data stable while out_valid & ~out_ready. Order strictly FIFO.
//  - flush has priority over all: next edge -> E, in_ready=1; concurrent
//    accept discarded; out_data keeps last value, out_valid=0.
//  - sel_err: set on accepted bad select (also during flush); err_clr clears;
//    set wins over simultaneous clear. Unchanged by flush.
//  - When N is a power of two sel_err never sets.
//  - Inputs not sampled when in_ready=0; in_sel/in_data may change freely.
// TESTING
//  1 Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0,
//    sel_err=0 immediately (no clock); in_ready=1 after release.
//  2 Streaming N=4: in_data={D3,D2,D1,D0}, sel=2,0,3 with out_ready=1 ->
//    out_data D2,D0,D3 on consecutive cycles, 1-cycle latency, no bubbles.
//  3 Backpressure: out_ready=0, push A,B -> in_ready=0 after B, out_data=A
//    held; raise out_ready -> A, then B, in_ready=1 one cycle after A leaves.
//  4 Bad select N=3: sel=3 accepted -> out_data=0, sel_err=1; err_clr with a
//    second bad select same edge -> sel_err stays 1; err_clr alone -> 0.
//  5 Flush: stage full (F), flush=1 with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1, neither buffered word nor concurrent word ever emitted.
//  6 Random: random valid/ready/sel, N=5 WIDTH=8, 10k cycles vs scoreboard ->
//    no loss, duplication or reorder; out_data stable under stall.

Source files
------------

// File: rtl/mux_pipe_stage.sv
// N-way, WIDTH-bit selector with a registered, valid/ready handshaked output.
// The selected word is captured into a main register that drives the output;
// a second skid register absorbs one extra word under backpressure so that
// in_ready can be registered (no combinational path from out_ready).
// Out-of-range selects produce an all-zero word and set a sticky error flag.
module mux_pipe_stage #(
    parameter  int WIDTH = 32,
    parameter  int N     = 2,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 sel_err,
    input  logic                 err_clr
);

    // Storage: main register drives the output, skid holds the overflow word
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             sel_err_q,    sel_err_d;

    logic [WIDTH-1:0] chan [N];
    logic [WIDTH-1:0] sel_word;
    logic             sel_bad;
    logic             accept;

    // Split the flat input bus into per-channel words
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A select is bad when it names a channel that does not exist; this can
    // only happen when N is not a power of two.
    assign sel_bad = (32'(in_sel) >= 32'(N));

    // Select the channel word; an out-of-range select leaves it at zero
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SELW'(k)) begin
                sel_word = chan[k];
            end
        end
    end

    // Ready depends only on skid occupancy, so it is a pure register output
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;

    // Occupancy transitions: empty / main only / main+skid, flush dominant
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            // Drop everything held and anything offered; data keeps last value
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = sel_word;
            end
        end else if (!skid_valid_q) begin
            if (out_ready && accept) begin
                main_data_d  = sel_word;
            end else if (out_ready) begin
                main_valid_d = 1'b0;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = sel_word;
            end
        end else if (out_ready) begin
            // Both full: main drains, skid word moves up; no accept possible
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end
    end

    // Sticky select error: a new bad accept wins over a simultaneous clear
    always_comb begin
        sel_err_d = (accept & sel_bad) | (sel_err_q & ~err_clr);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign sel_err   = sel_err_q;

endmodule
